// File: rtl/logic_serial_ctrl.sv
// logic_serial_ctrl
//   Bit-serial sequencer for the single-bit AND/NAND/NOR/OR logic unit.
//   Applies one function to two WIDTH-bit words, LSB first, one bit per
//   cycle. The external unit's combinational output lu_y is shifted into
//   the result register MSB-first, so bit i ends up at result[i].
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request pulse, accepted only in IDLE
//   a, b, op      operands and function (0=AND 1=NAND 2=NOR 3=OR), latched on accept
//   busy          high in RUN and DONE
//   done          one-cycle completion pulse
//   result        last completed result, held until the next completion
//   lu_a, lu_b    current operand bits to the logic unit
//   lu_sel        function select to the logic unit
//   lu_y          logic-unit output, sampled at the clock edge
module logic_serial_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lu_a,
  output logic             lu_b,
  output logic [1:0]       lu_sel,
  input  logic             lu_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit = (cnt == LAST);

  // Written as shift-then-insert so WIDTH=1 needs no zero-width slice.
  always_comb begin
    r_nxt            = r_sh >> 1;
    r_nxt[WIDTH-1]   = lu_y;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      op_r   <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            op_r <= op;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nxt;
          // Hold the counter on the final bit so it never passes WIDTH-1.
          if (last_bit) result <= r_nxt;
          else          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Logic-unit drive comes only from registers, never from start/a/b/op.
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    lu_a   = 1'b0;
    lu_b   = 1'b0;
    lu_sel = 2'd0;
    if (state == RUN) begin
      lu_a   = a_sh[0];
      lu_b   = b_sh[0];
      lu_sel = op_r;
    end
  end

endmodule

// File: tb/tb_logic_serial_ctrl.sv
module tb_logic_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [1:0] op = '0;
  logic       busy, done, lu_a, lu_b, lu_y;
  logic [7:0] result;
  logic [1:0] lu_sel;

  // WIDTH=1 instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [1:0] op1 = '0;
  logic       busy1, done1, lu_a1, lu_b1, lu_y1;
  logic [0:0] result1;
  logic [1:0] lu_sel1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic lu_model(input logic x, input logic y, input logic [1:0] s);
    case (s)
      2'd0:    return x & y;
      2'd1:    return ~(x & y);
      2'd2:    return ~(x | y);
      default: return x | y;
    endcase
  endfunction

  assign lu_y  = lu_model(lu_a, lu_b, lu_sel);
  assign lu_y1 = lu_model(lu_a1, lu_b1, lu_sel1);

  logic_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_y(lu_y)
  );

  logic_serial_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .op(op1),
    .busy(busy1), .done(done1), .result(result1),
    .lu_a(lu_a1), .lu_b(lu_b1), .lu_sel(lu_sel1), .lu_y(lu_y1)
  );

  // Issues one operation at the current negedge and follows it to the DONE
  // cycle; operands are scrambled after accept to show they are not reused.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [1:0] top, input logic [7:0] exp,
                        input logic [7:0] prev, input string nm);
    int dones;
    dones = 0;
    start = 1'b1; a = ta; b = tb_v; op = top;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; a = ~ta; b = ~tb_v; op = ~top;
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL %s busy cyc%0d got %b exp 1", nm, i, busy);
      end
      n_checks++;
      if (done !== (i == 9)) begin
        n_fail++; $display("FAIL %s done cyc%0d got %b exp %b", nm, i, done, (i == 9));
      end
      n_checks++;
      if (lu_sel !== ((i <= 8) ? top : 2'd0)) begin
        n_fail++; $display("FAIL %s lu_sel cyc%0d got %0d exp %0d", nm, i, lu_sel, (i <= 8) ? top : 2'd0);
      end
      if (done === 1'b1) dones++;
      if (i <= 8) begin
        n_checks++;
        if (result !== prev) begin
          n_fail++; $display("FAIL %s result_hold cyc%0d got %h exp %h", nm, i, result, prev);
        end
      end
    end
    n_checks++;
    if (result !== exp) begin
      n_fail++; $display("FAIL %s result got %h exp %h", nm, result, exp);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL %s done_count got %0d exp 1", nm, dones);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, lu_a, lu_b, lu_sel} !== 6'b0) begin
      n_fail++; $display("FAIL reset ctrl got %b exp 000000", {busy, done, lu_a, lu_b, lu_sel});
    end
    n_checks++;
    if (result !== 8'h00) begin
      n_fail++; $display("FAIL reset result got %h exp 00", result);
    end
    n_checks++;
    if ({busy1, done1, result1} !== 3'b0) begin
      n_fail++; $display("FAIL reset w1 got %b exp 000", {busy1, done1, result1});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_and();
    run_op(8'hF0, 8'h3C, 2'd0, 8'h30, 8'h00, "and");
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL and_idle busy/done got %b exp 00", {busy, done});
    end
  endtask

  task automatic test_back_to_back();
    run_op(8'hF0, 8'h3C, 2'd1, 8'hCF, 8'h30, "nand");
    @(negedge clk);
    run_op(8'hA5, 8'h0F, 2'd2, 8'h50, 8'hCF, "nor");
    @(negedge clk);
    run_op(8'hA5, 8'h0F, 2'd3, 8'hAF, 8'h50, "or");
  endtask

  task automatic test_start_ignored();
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; a = 8'hF0; b = 8'h3C; op = 2'd0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 8'hFF; b = 8'hFF; op = 2'd3;
      end
      if (done === 1'b1) dones++;
      if (i == 9) start = 1'b0;
    end
    n_checks++;
    if (result !== 8'h30) begin
      n_fail++; $display("FAIL ignore result got %h exp 30", result);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL ignore busy_after cyc%0d got %b exp 0", i, busy);
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL ignore done_count got %0d exp 1", dones);
    end
  endtask

  task automatic test_lu_drive();
    logic [7:0] av;
    av = 8'h81;
    n_checks++;
    if ({lu_a, lu_b, lu_sel} !== 4'b0) begin
      n_fail++; $display("FAIL lu_idle got %b exp 0000", {lu_a, lu_b, lu_sel});
    end
    start = 1'b1; a = av; b = 8'hFF; op = 2'd0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      n_checks++;
      if (lu_a !== ((i <= 8) ? av[i-1] : 1'b0)) begin
        n_fail++; $display("FAIL lu_a cyc%0d got %b exp %b", i, lu_a, (i <= 8) ? av[i-1] : 1'b0);
      end
      n_checks++;
      if (lu_b !== (i <= 8)) begin
        n_fail++; $display("FAIL lu_b cyc%0d got %b exp %b", i, lu_b, (i <= 8));
      end
      n_checks++;
      if (lu_sel !== 2'd0) begin
        n_fail++; $display("FAIL lu_sel0 cyc%0d got %0d exp 0", i, lu_sel);
      end
    end
    n_checks++;
    if (result !== 8'h81) begin
      n_fail++; $display("FAIL lu_run result got %h exp 81", result);
    end
    @(negedge clk);
    n_checks++;
    if ({lu_a, lu_b, lu_sel} !== 4'b0) begin
      n_fail++; $display("FAIL lu_idle2 got %b exp 0000", {lu_a, lu_b, lu_sel});
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1; a = 8'h0F; b = 8'h30; op = 2'd3;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL midrst busy/done got %b exp 00", {busy, done});
    end
    n_checks++;
    if (result !== 8'h00) begin
      n_fail++; $display("FAIL midrst result got %h exp 00", result);
    end
    n_checks++;
    if (lu_sel !== 2'd0) begin
      n_fail++; $display("FAIL midrst lu_sel got %0d exp 0", lu_sel);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        n_fail++; $display("FAIL midrst quiet cyc%0d got %b exp 00", i, {busy, done});
      end
    end
    run_op(8'h0F, 8'h30, 2'd3, 8'h3F, 8'h00, "after_rst");
  endtask

  task automatic test_width1();
    @(negedge clk);
    start1 = 1'b1; a1 = 1'b0; b1 = 1'b0; op1 = 2'd2;
    @(negedge clk);
    start1 = 1'b0;
    n_checks++;
    if ({busy1, done1, lu_sel1} !== 4'b1010) begin
      n_fail++; $display("FAIL w1 run got %b exp 1010", {busy1, done1, lu_sel1});
    end
    @(negedge clk);
    n_checks++;
    if ({busy1, done1, result1} !== 3'b111) begin
      n_fail++; $display("FAIL w1 done got %b exp 111", {busy1, done1, result1});
    end
    @(negedge clk);
    n_checks++;
    if ({busy1, done1, result1} !== 3'b001) begin
      n_fail++; $display("FAIL w1 idle got %b exp 001", {busy1, done1, result1});
    end
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; op1 = 2'd1;
    @(negedge clk);
    start1 = 1'b0;
    n_checks++;
    if (result1 !== 1'b1) begin
      n_fail++; $display("FAIL w1 hold got %b exp 1", result1);
    end
    @(negedge clk);
    n_checks++;
    if ({done1, result1} !== 2'b10) begin
      n_fail++; $display("FAIL w1 nand got %b exp 10", {done1, result1});
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_back_to_back();
    test_start_ignored();
    test_lu_drive();
    test_mid_reset();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_serial_ctrl.md
Name: logic_serial_ctrl

Overview:
Sequencer that drives the team's single-bit, four-function logic unit (AND/NAND/NOR/OR) to perform the same operation on two WIDTH-bit words. It processes one bit per cycle, LSB first. It latches the operands and op code on start, presents one bit pair per cycle to the external logic unit, and shifts the returned bit into a result register. A start/busy/done handshake is used toward the issuing control logic.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
op  input  2  function: 0=AND, 1=NAND, 2=NOR, 3=OR; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid from this cycle on
result  output  WIDTH  last completed result; held until next completion
lu_a  output  1  bit of A to logic unit
lu_b  output  1  bit of B to logic unit
lu_sel  output  2  function select to logic unit
lu_y  input  1  combinational logic-unit output; sampled at clk edge

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, result=0, lu_a=0, lu_b=0, lu_sel=0; counter=0; shift registers cleared. Reset takes priority over all other inputs, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - lu_a/lu_b/lu_sel driven 0.
  - On start=1: load a_sh=a, b_sh=b, op_r=op, cnt=0; go to RUN.
  - On start=0: stay in IDLE.
- RUN:
  - lu_a=a_sh[0], lu_b=b_sh[0], lu_sel=op_r. All three are register-derived, so there is no combinational path from start/a/b/op.
  - Each cycle: r_sh <= {lu_y, r_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; cnt <= cnt+1.
  - When cnt==WIDTH-1: load result <= {lu_y, r_sh[WIDTH-1:1]} and go to DONE.
- DONE:
  - done=1 for exactly this cycle; lu_* driven 0.
  - Go to IDLE unconditionally.
- start is ignored in RUN and DONE; no queuing. A start in the cycle after done (IDLE) is accepted.
- Latency: start sampled at edge 0 -> RUN occupies edges 1..WIDTH -> done=1 in the cycle following edge WIDTH. Issue interval is WIDTH+2 cycles.
- result changes only on the final RUN edge. It is stable otherwise, including while the next operation is in RUN.
- Bit ordering: bit i of result = F(a[i], b[i]), where F is the function selected by op.
- Changes on a, b, or op after start is accepted have no effect.
- WIDTH=1: RUN lasts a single cycle, cnt stays 0, and the final-edge rule applies on the first RUN edge.
- cnt never exceeds WIDTH-1, so there is no wrap in normal operation. It is cleared on accept and on reset.

Test Plan:
1. WIDTH=8, op=0, a=0xF0, b=0x3C, start pulse -> busy=1 for 9 cycles, done pulses exactly once in the 9th cycle after the start edge, result=0x30.
2. op=1, a=0xF0, b=0x3C -> result=0xCF. Then op=2, a=0xA5, b=0x0F -> result=0x50. Then op=3, same operands -> result=0xAF. Back-to-back issue: start raised the cycle after done is accepted.
3. During RUN, hold start=1 and change a=0xFF, b=0xFF, op=3 -> ignored; result equals the first-latched operation's value, and only one done pulse occurs.
4. Monitor lu_a/lu_b/lu_sel during the op=0, a=0x81, b=0xFF run -> lu_a sequence 1,0,0,0,0,0,0,1, lu_b all 1, lu_sel=0. All three are 0 in IDLE and DONE.
5. Assert rst at the 4th RUN cycle -> next cycle busy=0, done=0, result=0, state IDLE, no done pulse afterwards. A fresh start then completes normally with the correct value.
6. WIDTH=1 build, op=2, a=0, b=0 -> done at the 2nd cycle after start, result=1.
